dmem_dump_arbiter: RTL and testbench

- Sits between the CPU data port and the single-ported data memory. The memory has combinational read and a registered write.
- Adds an internal dump engine: on a start pulse it reads a block of words out of memory and streams them on a valid/ready test port.
- Arbitrates the memory between CPU and dump engine. The CPU has priority; a starvation counter forces the dump engine through periodically and stalls the CPU for that cycle.

---
 rtl/dmem_dump_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_dump_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter
// Shares a single-ported data memory between the CPU data port and an
// internal dump engine. The dump engine reads a block of words, starting at
// a base address, and streams them out on a valid/ready port. The CPU
// normally has priority. A starvation counter periodically forces one dump
// fetch through, and that cycle stalls the CPU.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cpu_read/cpu_write/cpu_addr   CPU request
//   cpu_wdata                     CPU write data
//   cpu_rdata                     CPU read data (combinational, 0 when not served)
//   cpu_stall                     CPU access not performed; CPU holds its request
//   dump_start/base/len           dump command (base, len sampled on start)
//   dump_data/valid/ready         dumped word stream (registered data)
//   dump_busy, dump_done          dump in progress / one-cycle completion pulse
//   mem_read/write/addr/wdata     memory request
//   mem_rdata                     memory read data (combinational from mem_addr)
//
// state | meaning
// IDLE  | waiting for dump_start
// FETCH | dump engine wants the memory; waits for a grant (CPU idle or starved)
// HOLD  | word presented on dump port; waits for the consumer to accept it
module dmem_dump_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [LEN_W-1:0]  dump_len,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  idx;
  logic [STV_W-1:0]  starve;

  logic              cpu_req;
  logic              starved;
  logic              dump_grant;
  logic              last_word;
  logic [ADDR_W-1:0] dump_addr;

  assign cpu_req    = cpu_read | cpu_write;
  assign starved    = (starve == STV_W'(STARVE_MAX));
  assign dump_grant = (state == FETCH) & (~cpu_req | starved);
  assign last_word  = (idx == (len - 1'b1));
  // idx is zero-extended; the sum wraps naturally at ADDR_W bits.
  assign dump_addr  = base + ADDR_W'(idx);

  always_comb begin
    mem_read  = cpu_read;
    mem_write = cpu_write;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dump_grant) begin
      mem_read  = 1'b1;
      mem_write = 1'b0;
      mem_addr  = dump_addr;
    end
  end

  assign cpu_stall = dump_grant & cpu_req;
  assign cpu_rdata = (cpu_read & ~cpu_stall) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      idx        <= '0;
      starve     <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dump_start) begin
            if (dump_len != '0) begin
              base      <= dump_base;
              len       <= dump_len;
              idx       <= '0;
              starve    <= '0;
              dump_busy <= 1'b1;
              state     <= FETCH;
            end else begin
              // Empty dump completes immediately without touching memory.
              dump_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (dump_grant) begin
            dump_data  <= mem_rdata;
            dump_valid <= 1'b1;
            starve     <= '0;
            state      <= HOLD;
          end else if (!starved) begin
            starve <= starve + 1'b1;
          end
        end
        HOLD: begin
          if (dump_valid & dump_ready) begin
            dump_valid <= 1'b0;
            if (last_word) begin
              dump_busy <= 1'b0;
              dump_done <= 1'b1;
              state     <= IDLE;
            end else begin
              idx   <= idx + 1'b1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
module tb_dmem_dump_arbiter;

  localparam int SM = 15;

  logic        clk;
  logic        rst_n;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dump_start;
  logic [31:0] dump_base;
  logic [7:0]  dump_len;
  logic [31:0] dump_data;
  logic        dump_valid, dump_ready, dump_busy, dump_done;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_dump_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(8), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dump_start(dump_start), .dump_base(dump_base), .dump_len(dump_len),
    .dump_data(dump_data), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_busy(dump_busy), .dump_done(dump_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    if (a >= 8'd50 && a <= 8'd59) return 32'(a - 8'd50);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Memory environment: combinational read, registered write, indexed by addr[7:0].
  logic        mem_init;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
    end else if (mem_write) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  // Reference view of memory contents, updated only by intended CPU writes.
  logic [31:0] shadow [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0] data;
    bit          last;
  } word_t;

  word_t       exp_data_q[$];
  logic [31:0] exp_addr_q[$];
  bit          model_busy = 1'b0;
  bit          done_exp   = 1'b0;
  bit          last_stall = 1'b0;
  word_t       mon_w;
  logic [31:0] mon_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_data_q.delete();
      exp_addr_q.delete();
      model_busy = 1'b0;
      done_exp   = 1'b0;
      last_stall = 1'b0;
    end else begin
      chk("dump_done", dump_done, done_exp);
      done_exp = 1'b0;
      chk("dump_busy", dump_busy, model_busy);
      if (cpu_stall) begin
        chk("stall_without_req", cpu_read | cpu_write, 1);
        chk("stalled_write_blocked", mem_write, 0);
      end
      if (cpu_read && !cpu_stall) chk("cpu_rdata", cpu_rdata, shadow[cpu_addr[7:0]]);
      if (cpu_read && cpu_stall) chk("cpu_rdata_stalled", cpu_rdata, 0);
      if ((cpu_read || cpu_write) && !cpu_stall) chk("cpu_addr_pass", mem_addr, cpu_addr);
      if (mem_read && (cpu_stall || !(cpu_read || cpu_write))) begin
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_dump_read: got addr %h expected none", mem_addr);
        end else begin
          mon_a = exp_addr_q.pop_front();
          chk("dump_addr", mem_addr, mon_a);
        end
      end
      if (dump_start && !model_busy) begin
        if (dump_len == 8'd0) begin
          done_exp = 1'b1;
        end else begin
          model_busy = 1'b1;
          for (int k = 0; k < int'(dump_len); k++) begin
            mon_a = dump_base + 32'(k);
            exp_addr_q.push_back(mon_a);
            mon_w.data = shadow[mon_a[7:0]];
            mon_w.last = (k == int'(dump_len) - 1);
            exp_data_q.push_back(mon_w);
          end
        end
      end
      if (dump_valid && dump_ready) begin
        if (exp_data_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_dump_word: got %h expected none", dump_data);
        end else begin
          mon_w = exp_data_q.pop_front();
          chk("dump_data", dump_data, mon_w.data);
          if (mon_w.last) begin
            done_exp   = 1'b1;
            model_busy = 1'b0;
          end
        end
      end
      last_stall = cpu_stall;
    end
  end

  // Stimulus helpers; all stimulus changes happen 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic start_dump(input logic [31:0] b, input logic [7:0] l);
    dump_start = 1'b1;
    dump_base  = b;
    dump_len   = l;
    cyc(1);
    dump_start = 1'b0;
  endtask

  task automatic drive_random();
    dump_ready = ($urandom % 4) != 0;
    dump_start = ($urandom % 8) == 0;
    dump_base  = $urandom;
    dump_len   = 8'($urandom % 16);
    if (!last_stall) begin
      if (($urandom % 3) == 0) begin
        cpu_read = 1'b0;
      end else begin
        cpu_read = 1'b1;
        cpu_addr = $urandom;
      end
    end
  endtask

  task automatic wait_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    while ((model_busy || exp_data_q.size() != 0 || done_exp) && n < budget) begin
      if (rnd) drive_random();
      cyc(1);
      n++;
    end
    dump_start = 1'b0;
    cpu_read   = 1'b0;
    dump_ready = 1'b1;
    chk("idle_within_budget", 32'(n < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(8'(i));
    rst_n = 1'b0; mem_init = 1'b1;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dump_start = 1'b0; dump_base = '0; dump_len = '0; dump_ready = 1'b1;
    cyc(3);
    mem_init = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", dump_valid, 0);
    chk("reset_busy", dump_busy, 0);
    chk("reset_done", dump_done, 0);
    chk("reset_data", dump_data, 0);
    chk("reset_stall", cpu_stall, 0);
    cyc(1);

    // Basic dump with idle CPU: words on alternate cycles.
    start_dump(32'd50, 8'd4);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("t1_valid", dump_valid, 32'((k % 2 == 0) && k <= 8));
      if (k % 2 == 0 && k <= 8) chk("t1_data", dump_data, 32'(k / 2 - 1));
    end
    cyc(1);
    wait_idle(1'b0, 50);

    // Backpressure on word 2.
    start_dump(32'd50, 8'd4);
    cyc(4);
    dump_ready = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 5; j++) begin
      cyc(1);
      @(negedge clk);
      chk("t2_hold_valid", dump_valid, 1);
      chk("t2_hold_data", dump_data, 2);
    end
    cyc(1);
    dump_ready = 1'b1;
    wait_idle(1'b0, 50);

    // Starvation: CPU reads every cycle during a 2-word dump.
    cpu_read = 1'b1; cpu_addr = 32'd7;
    start_dump(32'd70, 8'd2);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("t3_stall", cpu_stall, 32'(k == SM + 1 || k == 2 * (SM + 1) + 1));
      if (k == SM + 1) chk("t3_forced_addr", mem_addr, 32'd70);
      cyc(1);
    end
    cpu_read = 1'b0;
    wait_idle(1'b0, 50);

    // Zero-length dump, then start while busy.
    start_dump(32'd10, 8'd0);
    @(negedge clk);
    chk("t5_len0_busy", dump_busy, 0);
    chk("t5_len0_valid", dump_valid, 0);
    cyc(1);
    start_dump(32'd60, 8'd3);
    cyc(2);
    start_dump(32'd0, 8'd5);
    wait_idle(1'b0, 50);
    cyc(3);

    // Reset in the middle of a dump.
    start_dump(32'd50, 8'd4);
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", dump_valid, 0);
    chk("t6_rst_busy", dump_busy, 0);
    chk("t6_rst_done", dump_done, 0);
    chk("t6_rst_data", dump_data, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    start_dump(32'd55, 8'd2);
    wait_idle(1'b0, 50);

    // Address wrap.
    start_dump(32'hFFFF_FFFE, 8'd3);
    wait_idle(1'b0, 50);

    // CPU write to 52 caught by a forced slot, retried the next cycle.
    cpu_read = 1'b1; cpu_addr = 32'd7;
    start_dump(32'd100, 8'd1);
    cyc(SM);
    cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 32'd52; cpu_wdata = 32'hAA;
    @(negedge clk);
    chk("t4_stall", cpu_stall, 1);
    chk("t4_no_write", mem_write, 0);
    cyc(1);
    @(negedge clk);
    chk("t4_retry_stall", cpu_stall, 0);
    chk("t4_retry_write", mem_write, 1);
    chk("t4_retry_addr", mem_addr, 32'd52);
    chk("t4_retry_wdata", mem_wdata, 32'hAA);
    cyc(1);
    cpu_write = 1'b0;
    shadow[52] = 32'hAA;
    wait_idle(1'b0, 50);
    cpu_read = 1'b1; cpu_addr = 32'd52;
    cyc(1);
    cpu_read = 1'b0;
    start_dump(32'd50, 8'd4);
    wait_idle(1'b0, 50);

    // Randomized traffic.
    for (int r = 0; r < 12; r++) begin
      start_dump($urandom, 8'(1 + $urandom % 12));
      wait_idle(1'b1, 3000);
      cyc(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
